// File: rtl/reg64_serial_reader_if.sv
// Bus bundle between reg64_serial_reader and its neighbours: frame request, parallel word from
// the register, read strobe back to it, and the qualified serial stream.
interface reg64_serial_reader_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             read;
  logic             busy;
  logic             sout;
  logic             sout_valid;
  logic             frame_done;

  modport master (
    output start, data_in,
    input  read, busy, sout, sout_valid, frame_done
  );

  modport slave (
    input  start, data_in,
    output read, busy, sout, sout_valid, frame_done
  );
endinterface

// File: rtl/reg64_serial_reader.sv
// Fetches a word from the 64-bit register on start and shifts it out bit-serially.
// Optional feature: define PARITY_EN to append an even-parity bit after the last data bit.
module reg64_serial_reader #(
  parameter int unsigned WIDTH     = 64,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  reg64_serial_reader_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StShift   = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
`ifdef PARITY_EN
  localparam logic [2:0] StParity  = 3'd5;
`endif

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             read_q, read_d;
  logic             busy_q, busy_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Outputs are registered, so each one is derived from the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    read_d  = 1'b0;
    sout_d  = 1'b1;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StFetch;
          read_d  = 1'b1;
        end
      end
      StFetch: begin
        state_d = StCapture;
        read_d  = 1'b1;
      end
      StCapture: begin
        // shreg keeps only the bits still to be sent; the first goes straight to sout.
        state_d = StShift;
        cnt_d   = '0;
        valid_d = 1'b1;
        shreg_d = LSB_FIRST ? (bus.data_in >> 1) : (bus.data_in << 1);
        sout_d  = LSB_FIRST ? bus.data_in[0] : bus.data_in[WIDTH-1];
`ifdef PARITY_EN
        parity_d = ^bus.data_in;
`endif
      end
      StShift: begin
        if (cnt_q == LastCnt) begin
`ifdef PARITY_EN
          state_d = StParity;
          sout_d  = parity_q;
          valid_d = 1'b1;
`else
          state_d = StDone;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d   = cnt_q + 1'b1;
          valid_d = 1'b1;
          sout_d  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        end
      end
`ifdef PARITY_EN
      StParity: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      sout_q  <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      sout_q  <= sout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign bus.read       = read_q;
  assign bus.busy       = busy_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = valid_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_reg64_serial_reader.sv
// Scoreboard bench for reg64_serial_reader: an LSB-first and an MSB-first instance, expected serial
// bits queued at stimulus time and popped by per-instance monitors on the falling edge.
module tb_reg64_serial_reader;

  localparam int unsigned W = 64;
`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  reg64_serial_reader_if #(.WIDTH(W)) bus ();
  reg64_serial_reader_if #(.WIDTH(W)) busm ();

  reg64_serial_reader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  reg64_serial_reader #(.WIDTH(W), .LSB_FIRST(1'b0)) dutm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busm)
  );

  int tests = 0;
  int fails = 0;
  int q[$];   // 0/1 = expected data bit, 2 = expected frame_done
  int qm[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [63:0] d, input bit msb);
    for (int i = 0; i < W; i++) begin
      int b;
      b = msb ? int'(d[W-1-i]) : int'(d[i]);
      if (msb) qm.push_back(b); else q.push_back(b);
    end
    if (P != 0) begin
      if (msb) qm.push_back(int'(^d)); else q.push_back(int'(^d));
    end
    if (msb) qm.push_back(2); else q.push_back(2);
  endtask

  // LSB-first monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sout_valid || bus.frame_done) begin
        int e;
        if (q.size() == 0) begin
          check("lsb_unexpected_out", {62'b0, bus.sout_valid, bus.frame_done}, 64'd0);
        end else begin
          e = q.pop_front();
          if (e == 2) begin
            check("lsb_frame_done", {63'b0, bus.frame_done}, 64'd1);
            check("lsb_done_valid", {63'b0, bus.sout_valid}, 64'd0);
            check("lsb_done_sout", {63'b0, bus.sout}, 64'd1);
          end else begin
            check("lsb_bit_valid", {63'b0, bus.sout_valid}, 64'd1);
            check("lsb_bit", {63'b0, bus.sout}, 64'(e));
          end
        end
      end else begin
        check("lsb_idle_sout", {63'b0, bus.sout}, 64'd1);
      end
    end
  end

  // MSB-first monitor
  always @(negedge clk) begin
    if (rst_n && (busm.sout_valid || busm.frame_done)) begin
      int e;
      if (qm.size() == 0) begin
        check("msb_unexpected_out", {62'b0, busm.sout_valid, busm.frame_done}, 64'd0);
      end else begin
        e = qm.pop_front();
        if (e == 2) begin
          check("msb_frame_done", {63'b0, busm.frame_done}, 64'd1);
        end else begin
          check("msb_bit_valid", {63'b0, busm.sout_valid}, 64'd1);
          check("msb_bit", {63'b0, busm.sout}, 64'(e));
        end
      end
    end
  end

  // Single frame on the LSB instance, with timing checks and data_in disturbance mid-frame.
  task automatic run_frame(input logic [63:0] d);
    int read_cnt, busy_cnt, done_edge;
    read_cnt  = 0;
    busy_cnt  = 0;
    done_edge = -1;
    @(posedge clk);
    #1;
    bus.data_in = d;
    bus.start   = 1'b1;
    push_frame(d, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.read) read_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.frame_done) done_edge = i;
      if (i == 3) bus.data_in = ~d;
      if (i == 20) bus.start = 1'b1;
      if (i == 21) bus.start = 1'b0;
      if (!bus.busy) break;
    end
    check("read_cycles", 64'(read_cnt), 64'd2);
    check("busy_cycles", 64'(busy_cnt), 64'(W + 3 + P));
    check("frame_done_edge", 64'(done_edge), 64'(W + 2 + P));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.data_in  = '0;
    busm.start   = 1'b0;
    busm.data_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_read", {63'b0, bus.read}, 64'd0);
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_sout", {63'b0, bus.sout}, 64'd1);
    check("rst_valid", {63'b0, bus.sout_valid}, 64'd0);
    check("rst_done", {63'b0, bus.frame_done}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic frame, then the parity pair (plain frames without PARITY_EN).
    run_frame(64'h59);
    run_frame(64'h25);
    run_frame(64'hDEAD_BEEF_0123_4567);

    // Asynchronous reset while data bit 10 is on sout.
    @(posedge clk);
    #1;
    bus.data_in = 64'hF0F0_1234_5678_0F0F;
    bus.start   = 1'b1;
    push_frame(64'hF0F0_1234_5678_0F0F, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sout", {63'b0, bus.sout}, 64'd1);
    check("midrst_busy", {63'b0, bus.busy}, 64'd0);
    check("midrst_read", {63'b0, bus.read}, 64'd0);
    check("midrst_valid", {63'b0, bus.sout_valid}, 64'd0);
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_frame(64'h59);

    // Start held high: three frames, one IDLE cycle between each.
    begin
      int started, dones, idle;
      bit prev_busy;
      started   = 0;
      dones     = 0;
      idle      = 0;
      prev_busy = 1'b0;
      @(posedge clk);
      #1;
      bus.data_in = 64'h8000_0000_0000_0001;
      for (int k = 0; k < 3; k++) push_frame(64'h8000_0000_0000_0001, 1'b0);
      bus.start = 1'b1;
      for (int i = 0; i < 400 && dones < 3; i++) begin
        @(negedge clk);
        if (bus.busy && !prev_busy) begin
          started++;
          if (started == 3) bus.start = 1'b0;
        end
        if (started > 0 && !bus.busy) idle++;
        if (bus.frame_done) dones++;
        prev_busy = bus.busy;
      end
      bus.start = 1'b0;
      check("b2b_frames", 64'(dones), 64'd3);
      check("b2b_starts", 64'(started), 64'd3);
      check("b2b_idle_gaps", 64'(idle), 64'd2);
      repeat (3) @(negedge clk);
      check("b2b_no_extra", {63'b0, bus.busy}, 64'd0);
    end

    // MSB-first instance.
    begin
      logic [63:0] mv [2];
      mv[0] = 64'hC000_0000_0000_0000;
      mv[1] = 64'h59;
      for (int k = 0; k < 2; k++) begin
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        busm.data_in = mv[k];
        busm.start   = 1'b1;
        push_frame(mv[k], 1'b1);
        @(posedge clk);
        #1;
        busm.start = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
          @(negedge clk);
          if (busm.frame_done) got = 1'b1;
        end
        check("msb_frame_seen", {63'b0, got}, 64'd1);
      end
    end

    repeat (5) @(posedge clk);
    check("lsb_queue_drained", 64'(q.size()), 64'd0);
    check("msb_queue_drained", 64'(qm.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
